// File: rtl/ram_sc_be_arb.sv
// Two-client round-robin arbiter and read-response sequencer for a single-clock byte-enable RAM.
// Optional same-cycle write->read forwarding is enabled by defining RAM_SC_BE_ARB_FWD_EN.
module ram_sc_be_arb #(
  parameter int unsigned ADDR_NBITS = 5,
  parameter int unsigned NUM_SPANS  = 8,
  parameter int unsigned SPAN_NBITS = 8
) (
  input  logic                                        clk_in,
  input  logic                                        rstn_in,
  input  logic [1:0]                                  wrValid_in,
  output logic [1:0]                                  wrReady_out,
  input  logic [1:0][ADDR_NBITS-1:0]                  wrAddr_in,
  input  logic [1:0][SPAN_NBITS*NUM_SPANS-1:0]        wrData_in,
  input  logic [1:0][NUM_SPANS-1:0]                   wrBe_in,
  input  logic [1:0]                                  rdValid_in,
  output logic [1:0]                                  rdReady_out,
  input  logic [1:0][ADDR_NBITS-1:0]                  rdAddr_in,
  output logic [1:0]                                  rspValid_out,
  output logic [SPAN_NBITS*NUM_SPANS-1:0]             rspData_out,
  output logic [ADDR_NBITS-1:0]                       ramWriteAddr_out,
  output logic [SPAN_NBITS*NUM_SPANS-1:0]             ramWriteData_out,
  output logic [NUM_SPANS-1:0]                        ramWriteEnable_out,
  output logic [ADDR_NBITS-1:0]                       ramReadAddr_out,
  input  logic [SPAN_NBITS*NUM_SPANS-1:0]             ramReadData_in
);

  localparam int unsigned W = SPAN_NBITS * NUM_SPANS;

  logic       prio_w;
  logic       prio_r;
  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;
  logic       wr_sel;
  logic       rd_sel;
  logic       own_vld;
  logic       own_cli;

  // Grants are gated by reset so nothing reaches the RAM while rstn_in is low.
  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (rstn_in) begin
      unique case (wrValid_in)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = prio_w ? 2'b10 : 2'b01;
        default: wr_gnt = '0;
      endcase
      unique case (rdValid_in)
        2'b01:   rd_gnt = 2'b01;
        2'b10:   rd_gnt = 2'b10;
        2'b11:   rd_gnt = prio_r ? 2'b10 : 2'b01;
        default: rd_gnt = '0;
      endcase
    end
  end

  assign wr_sel      = wr_gnt[1];
  assign rd_sel      = rd_gnt[1];
  assign wrReady_out = wr_gnt;
  assign rdReady_out = rd_gnt;

  assign ramWriteAddr_out   = (|wr_gnt) ? wrAddr_in[wr_sel] : '0;
  assign ramWriteData_out   = wrData_in[wr_sel];
  assign ramWriteEnable_out = (|wr_gnt) ? wrBe_in[wr_sel] : '0;
  assign ramReadAddr_out    = (|rd_gnt) ? rdAddr_in[rd_sel] : '0;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      prio_w  <= 1'b0;
      prio_r  <= 1'b0;
      own_vld <= 1'b0;
      own_cli <= 1'b0;
    end else begin
      if (|wr_gnt) prio_w <= ~wr_sel;
      if (|rd_gnt) prio_r <= ~rd_sel;
      own_vld <= |rd_gnt;
      own_cli <= rd_sel;
    end
  end

  assign rspValid_out = {own_vld & own_cli, own_vld & ~own_cli};

`ifdef RAM_SC_BE_ARB_FWD_EN
  logic                 fwd_vld;
  logic [W-1:0]         fwd_data;
  logic [NUM_SPANS-1:0] fwd_be;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      fwd_vld  <= 1'b0;
      fwd_data <= '0;
      fwd_be   <= '0;
    end else begin
      fwd_vld <= (|wr_gnt) && (|rd_gnt) && (wrAddr_in[wr_sel] == rdAddr_in[rd_sel]);
      if ((|wr_gnt) && (|rd_gnt) && (wrAddr_in[wr_sel] == rdAddr_in[rd_sel])) begin
        fwd_data <= wrData_in[wr_sel];
        fwd_be   <= wrBe_in[wr_sel];
      end
    end
  end

  // RAM returns pre-write data; overlay the spans the colliding write touched.
  always_comb begin
    rspData_out = ramReadData_in;
    if (fwd_vld) begin
      for (int unsigned s = 0; s < NUM_SPANS; s++) begin
        if (fwd_be[s]) rspData_out[s*SPAN_NBITS +: SPAN_NBITS] = fwd_data[s*SPAN_NBITS +: SPAN_NBITS];
      end
    end
  end
`else
  assign rspData_out = ramReadData_in;
`endif

endmodule

// File: tb/tb_ram_sc_be_arb.sv
// Self-checking bench for ram_sc_be_arb: directed vector table, hand sequences and a randomized
// run against a transaction-level model (round-robin rule plus a shadow memory).
module tb_ram_sc_be_arb;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 8;
  localparam int unsigned SW = 8;
  localparam int unsigned W  = NS * SW;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [1:0]           wv, rv;
  logic [1:0][AW-1:0]   wa, ra;
  logic [1:0][W-1:0]    wd;
  logic [1:0][NS-1:0]   wb;
  logic [1:0]           wr_ready, rd_ready, rsp_valid;
  logic [W-1:0]         rsp_data, ram_wdata, ram_rdata;
  logic [AW-1:0]        ram_waddr, ram_raddr;
  logic [NS-1:0]        ram_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_sc_be_arb #(.ADDR_NBITS(AW), .NUM_SPANS(NS), .SPAN_NBITS(SW)) dut (
    .clk_in(clk), .rstn_in(rstn),
    .wrValid_in(wv), .wrReady_out(wr_ready), .wrAddr_in(wa), .wrData_in(wd), .wrBe_in(wb),
    .rdValid_in(rv), .rdReady_out(rd_ready), .rdAddr_in(ra),
    .rspValid_out(rsp_valid), .rspData_out(rsp_data),
    .ramWriteAddr_out(ram_waddr), .ramWriteData_out(ram_wdata), .ramWriteEnable_out(ram_we),
    .ramReadAddr_out(ram_raddr), .ramReadData_in(ram_rdata)
  );

  // Behavioural block RAM: registered read, read-before-write, span enables.
  logic [W-1:0] ram_mem [32] = '{default: '0};
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_raddr];
    for (int s = 0; s < NS; s++)
      if (ram_we[s]) ram_mem[ram_waddr][s*SW +: SW] <= ram_wdata[s*SW +: SW];
  end

  // Reference model.
  logic [W-1:0] m_mem [32] = '{default: '0};
  logic         m_pw, m_pr, m_rv, m_rc;
  logic [W-1:0] m_rd, nrd;
  logic [1:0]   g_w, g_r;
  logic         cw, cr;

  function automatic logic [1:0] pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) return ptr ? 2'b10 : 2'b01;
    return req;
  endfunction

  always_comb begin
    g_w = pick(wv, m_pw);
    g_r = pick(rv, m_pr);
    cw  = (g_w == 2'b10);
    cr  = (g_r == 2'b10);
    nrd = m_mem[ra[cr]];
`ifdef RAM_SC_BE_ARB_FWD_EN
    if (g_w != 2'b00 && g_r != 2'b00 && wa[cw] == ra[cr])
      for (int s = 0; s < NS; s++)
        if (wb[cw][s]) nrd[s*SW +: SW] = wd[cw][s*SW +: SW];
`endif
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pw <= 1'b0; m_pr <= 1'b0; m_rv <= 1'b0; m_rc <= 1'b0; m_rd <= '0;
    end else begin
      m_rv <= (g_r != 2'b00);
      m_rc <= cr;
      m_rd <= nrd;
      if (g_w != 2'b00) begin
        m_pw <= ~cw;
        for (int s = 0; s < NS; s++)
          if (wb[cw][s]) m_mem[wa[cw]][s*SW +: SW] <= wd[cw][s*SW +: SW];
      end
      if (g_r != 2'b00) m_pr <= ~cr;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("wr_ready", 64'(wr_ready), 64'(g_w));
    chk("rd_ready", 64'(rd_ready), 64'(g_r));
    chk("wr_en", 64'(ram_we), (g_w != 2'b00) ? 64'(wb[cw]) : 64'd0);
    if (g_w != 2'b00) begin
      chk("wr_addr", 64'(ram_waddr), 64'(wa[cw]));
      chk("wr_data", 64'(ram_wdata), 64'(wd[cw]));
    end
    chk("rd_addr", 64'(ram_raddr), (g_r != 2'b00) ? 64'(ra[cr]) : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), m_rv ? (m_rc ? 64'd2 : 64'd1) : 64'd0);
    if (m_rv) chk("rsp_data", 64'(rsp_data), 64'(m_rd));
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, 31));
  endfunction

  typedef struct {
    logic [1:0] wv, rv, ew, er;
  } vec_t;
  vec_t tbl[9];

  logic [W-1:0] exp_col;
  logic [1:0]   acc_w, acc_r;

  initial begin
    tbl[0] = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[1] = '{2'b11, 2'b11, 2'b10, 2'b10};
    tbl[2] = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[3] = '{2'b11, 2'b11, 2'b10, 2'b10};
    tbl[4] = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[5] = '{2'b11, 2'b11, 2'b10, 2'b10};
    tbl[6] = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[7] = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[8] = '{2'b11, 2'b11, 2'b01, 2'b01};
`ifdef RAM_SC_BE_ARB_FWD_EN
    exp_col = 64'h00000000FFFFFFFF;
`else
    exp_col = 64'h0;
`endif

    // Reset with every request asserted.
    rstn = 1'b0; wv = 2'b11; rv = 2'b11;
    wa = '0; ra = '0; wd = '1; wb = '1;
    repeat (3) tick();
    #4;
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_wr_en", 64'(ram_we), 64'd0);
    chk("rst_rd_addr", 64'(ram_raddr), 64'd0);
    chk("rst_wr_addr", 64'(ram_waddr), 64'd0);
    tick();

    // Contention table; zero enables leave the RAM untouched.
    rstn = 1'b1; wb = '0; wa = {5'd9, 5'd8}; ra = {5'd2, 5'd1};
    for (int i = 0; i < 9; i++) begin
      wv = tbl[i].wv; rv = tbl[i].rv;
      #4;
      chk($sformatf("tbl%0d_wr", i), 64'(wr_ready), 64'(tbl[i].ew));
      chk($sformatf("tbl%0d_rd", i), 64'(rd_ready), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_we", i), 64'(ram_we), 64'd0);
      tick();
    end
    wv = '0; rv = '0;
    tick();

    // Full write by client 0, read by client 1 a cycle later.
    wv = 2'b01; wa[0] = 5'd5; wd[0] = 64'h1122334455667788; wb[0] = 8'hFF;
    #4;
    chk("wr5_ready", 64'(wr_ready), 64'd1);
    chk("wr5_en", 64'(ram_we), 64'hFF);
    chk("wr5_addr", 64'(ram_waddr), 64'd5);
    tick();
    wv = '0; rv = 2'b10; ra[1] = 5'd5;
    #4;
    chk("rd5_ready", 64'(rd_ready), 64'd2);
    chk("rd5_addr", 64'(ram_raddr), 64'd5);
    tick();
    rv = '0;
    #4;
    chk("rd5_rsp_valid", 64'(rsp_valid), 64'd2);
    chk("rd5_rsp_data", rsp_data, 64'h1122334455667788);
    tick();
    #4;
    chk("rd5_rsp_pulse", 64'(rsp_valid), 64'd0);
    tick();

    // Partial write of the low span only.
    wv = 2'b01; wd[0] = 64'hDEADBEEFCAFE00AA; wb[0] = 8'h01;
    tick();
    wv = '0; rv = 2'b01; ra[0] = 5'd5;
    #4;
    chk("prt_rd_ready", 64'(rd_ready), 64'd1);
    tick();
    rv = '0;
    #4;
    chk("prt_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("prt_rsp_data", rsp_data, 64'h11223344556677AA);
    tick();

    // Same-cycle write and read of row 7.
    wv = 2'b01; wa[0] = 5'd7; wd[0] = '1; wb[0] = 8'h0F;
    rv = 2'b10; ra[1] = 5'd7;
    #4;
    chk("col_wr_ready", 64'(wr_ready), 64'd1);
    chk("col_rd_ready", 64'(rd_ready), 64'd2);
    tick();
    wv = '0; rv = 2'b01; ra[0] = 5'd7;
    #4;
    chk("col_rsp_valid", 64'(rsp_valid), 64'd2);
    chk("col_rsp_data", rsp_data, exp_col);
    tick();
    rv = '0;
    #4;
    chk("col_after_data", rsp_data, 64'h00000000FFFFFFFF);
    tick();

    // Reset while a read is in flight; pointers were left at 1 by the grants below.
    wv = 2'b01; wb[0] = '0; rv = 2'b01; ra[0] = 5'd3;
    #4;
    chk("mid_rd_ready", 64'(rd_ready), 64'd1);
    tick();
    wv = '0; rv = '0; rstn = 1'b0;
    #4;
    chk("mid_rsp_dropped", 64'(rsp_valid), 64'd0);
    tick();
    rstn = 1'b1; wv = 2'b11; rv = 2'b11; wb = '0;
    #4;
    chk("mid_prio_w", 64'(wr_ready), 64'd1);
    chk("mid_prio_r", 64'(rd_ready), 64'd1);
    tick();
    wv = '0; rv = '0;
    tick();

    // Randomized traffic; requests hold until the model says they were accepted.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!wv[c] && $urandom_range(0, 2) != 0) begin
          wv[c] = 1'b1; wa[c] = rand_addr(); wd[c] = {$urandom, $urandom};
          wb[c] = ($urandom_range(0, 7) == 0) ? '0 : NS'($urandom);
        end
        if (!rv[c] && $urandom_range(0, 2) != 0) begin
          rv[c] = 1'b1; ra[c] = rand_addr();
        end
      end
      #4;
      check_model();
      acc_w = g_w; acc_r = g_r;
      tick();
      wv = wv & ~acc_w;
      rv = rv & ~acc_r;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
